// File: rtl/enemy_swarm_engine.sv
// Enemy pool manager: once per frame it walks the pool one slot per clock, moving, bouncing and
// colliding each live enemy with Mario. It also owns lives, invulnerability, score and game-over.
module enemy_swarm_engine #(
  parameter int NUM_ENEMIES     = 4,
  parameter int COORD_W         = 10,
  parameter int CHARACTER_WIDTH = 42,
  parameter int X_MIN           = 40,
  parameter int X_MAX           = 558,
  parameter int STEP            = 2,
  parameter int MAX_LIVES       = 3,
  parameter int INVULN_FRAMES   = 60
) (
  input  logic                           vga_clock,
  input  logic                           reset,
  input  logic                           frame_tick,
  input  logic                           restart,
  input  logic                           spawn_valid,
  input  logic [COORD_W-1:0]             spawn_x,
  input  logic [COORD_W-1:0]             spawn_y,
  input  logic                           spawn_dir,
  output logic                           spawn_ready,
  input  logic [COORD_W-1:0]             mario_x,
  input  logic [COORD_W-1:0]             mario_y,
  input  logic                           mario_falling,
  output logic [NUM_ENEMIES*COORD_W-1:0] enemy_x,
  output logic [NUM_ENEMIES*COORD_W-1:0] enemy_y,
  output logic [NUM_ENEMIES-1:0]         enemy_alive,
  output logic                           stomp_pulse,
  output logic                           hit_pulse,
  output logic [3:0]                     lives,
  output logic [15:0]                    score,
  output logic                           busy,
  output logic                           game_over,
  output logic                           overrun,
  output logic [1:0]                     fsm_state
);

  localparam int IDX_W = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1;
  localparam int INV_W = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_ENEMIES - 1);
  localparam logic [COORD_W:0]   STEP_E   = (COORD_W+1)'(STEP);
  localparam logic [COORD_W:0]   XMIN_E   = (COORD_W+1)'(X_MIN);
  localparam logic [COORD_W:0]   XMAX_E   = (COORD_W+1)'(X_MAX);
  localparam logic [COORD_W-1:0] CW_E     = COORD_W'(CHARACTER_WIDTH);
  localparam logic [INV_W-1:0]   INV_INIT = INV_W'(INVULN_FRAMES);
  localparam logic [3:0]         LIVES_INIT = 4'(MAX_LIVES);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_GAMEOVER = 2'd2} state_t;

  state_t               state, state_nx;
  logic [IDX_W-1:0]     idx;
  logic [COORD_W-1:0]   x_q [NUM_ENEMIES];
  logic [COORD_W-1:0]   y_q [NUM_ENEMIES];
  logic [NUM_ENEMIES-1:0] dir_q, alive_q;
  logic [INV_W-1:0]     invuln;

  logic [COORD_W:0]     cur_x, sum_x, nx_e;
  logic [COORD_W-1:0]   nx, cur_y, dx, dy;
  logic                 ndir, overlap, stomp, hit, last_life;
  logic [IDX_W-1:0]     spawn_slot;
  logic                 slot_found, spawn_fire;

  // Per-slot datapath for the slot under the scan index; extended by one bit so nothing wraps.
  always_comb begin
    cur_x = {1'b0, x_q[idx]};
    cur_y = y_q[idx];
    sum_x = cur_x + STEP_E;
    nx_e  = cur_x;
    ndir  = dir_q[idx];
    if (dir_q[idx]) begin
      if (sum_x >= XMAX_E) begin
        nx_e = XMAX_E;
        ndir = 1'b0;
      end else begin
        nx_e = sum_x;
      end
    end else begin
      if (cur_x < XMIN_E + STEP_E) begin
        nx_e = XMIN_E;
        ndir = 1'b1;
      end else begin
        nx_e = cur_x - STEP_E;
      end
    end
    nx        = nx_e[COORD_W-1:0];
    dx        = (nx >= mario_x) ? (nx - mario_x) : (mario_x - nx);
    dy        = (cur_y >= mario_y) ? (cur_y - mario_y) : (mario_y - cur_y);
    overlap   = (dx < CW_E) && (dy < CW_E);
    stomp     = (state == S_SCAN) && alive_q[idx] && overlap && mario_falling && (mario_y < cur_y);
    hit       = (state == S_SCAN) && alive_q[idx] && overlap && !stomp && (invuln == '0);
    last_life = hit && (lives == 4'd1);
  end

  // Spawn handshake: a slot is loaded on any edge where spawn_valid && spawn_ready;
  // spawn_ready depends only on state and alive flags, never on spawn_valid.
  always_comb begin
    spawn_slot = '0;
    slot_found = 1'b0;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      if (!alive_q[i] && !slot_found) begin
        spawn_slot = IDX_W'(i);
        slot_found = 1'b1;
      end
    end
  end

  assign spawn_fire = spawn_valid && spawn_ready;

  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset)        state <= S_IDLE;
    else if (restart) state <= S_IDLE;
    else              state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (frame_tick) state_nx = S_SCAN;
      S_SCAN: begin
        if (last_life)            state_nx = S_GAMEOVER;
        else if (idx == LAST_IDX) state_nx = S_IDLE;
      end
      S_GAMEOVER: state_nx = S_GAMEOVER;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state == S_SCAN);
    game_over   = (state == S_GAMEOVER);
    spawn_ready = (state == S_IDLE) && !(&alive_q);
    fsm_state   = state;
  end

  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      idx         <= '0;
      dir_q       <= '0;
      alive_q     <= '0;
      invuln      <= '0;
      lives       <= LIVES_INIT;
      score       <= '0;
      stomp_pulse <= 1'b0;
      hit_pulse   <= 1'b0;
      overrun     <= 1'b0;
      for (int i = 0; i < NUM_ENEMIES; i++) begin
        x_q[i] <= COORD_W'(X_MIN);
        y_q[i] <= '0;
      end
    end else if (restart) begin
      idx         <= '0;
      dir_q       <= '0;
      alive_q     <= '0;
      invuln      <= '0;
      lives       <= LIVES_INIT;
      score       <= '0;
      stomp_pulse <= 1'b0;
      hit_pulse   <= 1'b0;
      overrun     <= 1'b0;
      for (int i = 0; i < NUM_ENEMIES; i++) begin
        x_q[i] <= COORD_W'(X_MIN);
        y_q[i] <= '0;
      end
    end else begin
      stomp_pulse <= stomp;
      hit_pulse   <= hit;
      case (state)
        S_IDLE: begin
          if (frame_tick) begin
            idx <= '0;
            if (invuln != '0) invuln <= invuln - INV_W'(1);
          end
          if (spawn_fire) begin
            x_q[spawn_slot]     <= spawn_x;
            y_q[spawn_slot]     <= spawn_y;
            dir_q[spawn_slot]   <= spawn_dir;
            alive_q[spawn_slot] <= 1'b1;
          end
        end
        S_SCAN: begin
          if (frame_tick) overrun <= 1'b1;
          if (alive_q[idx]) begin
            x_q[idx]   <= nx;
            dir_q[idx] <= ndir;
          end
          if (stomp) begin
            alive_q[idx] <= 1'b0;
            if (score != 16'hFFFF) score <= score + 16'd1;
          end
          if (hit) begin
            lives  <= lives - 4'd1;
            invuln <= INV_INIT;
          end
          idx <= idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_ENEMIES; g++) begin : g_flat
    assign enemy_x[g*COORD_W +: COORD_W] = x_q[g];
    assign enemy_y[g*COORD_W +: COORD_W] = y_q[g];
  end
  assign enemy_alive = alive_q;

endmodule

// File: tb/tb_enemy_swarm_engine.sv
// Directed bench for enemy_swarm_engine: patrol bounce, stomp, hits with invulnerability,
// game-over and restart, overrun and asynchronous reset mid-scan.
module tb_enemy_swarm_engine;
  localparam int N = 4;
  localparam int W = 10;

  logic             vga_clock = 1'b0;
  logic             reset = 1'b1;
  logic             frame_tick = 1'b0;
  logic             restart = 1'b0;
  logic             spawn_valid = 1'b0;
  logic [W-1:0]     spawn_x = '0;
  logic [W-1:0]     spawn_y = '0;
  logic             spawn_dir = 1'b0;
  logic             spawn_ready;
  logic [W-1:0]     mario_x = 10'd1000;
  logic [W-1:0]     mario_y = 10'd1000;
  logic             mario_falling = 1'b0;
  logic [N*W-1:0]   enemy_x, enemy_y;
  logic [N-1:0]     enemy_alive;
  logic             stomp_pulse, hit_pulse;
  logic [3:0]       lives;
  logic [15:0]      score;
  logic             busy, game_over, overrun;
  logic [1:0]       fsm_state;

  int               check_cnt = 0;
  int               pass_cnt = 0;
  logic [W-1:0]     exp_q[$];

  enemy_swarm_engine dut (
    .vga_clock(vga_clock), .reset(reset), .frame_tick(frame_tick), .restart(restart),
    .spawn_valid(spawn_valid), .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_dir(spawn_dir),
    .spawn_ready(spawn_ready), .mario_x(mario_x), .mario_y(mario_y),
    .mario_falling(mario_falling), .enemy_x(enemy_x), .enemy_y(enemy_y),
    .enemy_alive(enemy_alive), .stomp_pulse(stomp_pulse), .hit_pulse(hit_pulse),
    .lives(lives), .score(score), .busy(busy), .game_over(game_over),
    .overrun(overrun), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 vga_clock = ~vga_clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [W-1:0] ex(input int i);
    return enemy_x[i*W +: W];
  endfunction

  task automatic step();
    @(posedge vga_clock);
    #1;
  endtask

  task automatic spawn(input logic [W-1:0] x, input logic [W-1:0] y, input logic d);
    spawn_x = x; spawn_y = y; spawn_dir = d; spawn_valid = 1'b1;
    step();
    spawn_valid = 1'b0;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  // Pulse frame_tick, then sample cycles E0+1 .. E0+N+1.
  task automatic run_frame(output int busy_n, output int stomp_n, output int stomp_at,
                           output int hit_n);
    busy_n = 0; stomp_n = 0; stomp_at = -1; hit_n = 0;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    for (int c = 1; c <= N + 1; c++) begin
      if (busy) busy_n++;
      if (stomp_pulse) begin stomp_n++; stomp_at = c; end
      if (hit_pulse) hit_n++;
      if (c <= N) step();
    end
  endtask

  initial begin
    int b, s, sa, h, hit_sum;
    #12 reset = 1'b0;
    step();

    check("rst_alive", 32'(enemy_alive), 32'd0);
    check("rst_lives", 32'(lives), 32'd3);
    check("rst_score", 32'(score), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gameover", 32'(game_over), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_x0", 32'(ex(0)), 32'd40);
    check("rst_ready", 32'(spawn_ready), 32'd1);

    // patrol and bounce at the right limit
    spawn(10'd550, 10'd300, 1'b1);
    check("spawn0_alive", 32'(enemy_alive), 32'd1);
    check("spawn0_x", 32'(ex(0)), 32'd550);
    exp_q.push_back(10'd552); exp_q.push_back(10'd554); exp_q.push_back(10'd556);
    exp_q.push_back(10'd558); exp_q.push_back(10'd556);
    for (int f = 0; f < 5; f++) begin
      run_frame(b, s, sa, h);
      check("patrol_busy", 32'(b), 32'd4);
      check("patrol_x", 32'(ex(0)), 32'(exp_q.pop_front()));
    end

    // fill the pool, stomp slot 2, refill it
    spawn(10'd100, 10'd100, 1'b0);
    spawn(10'd200, 10'd200, 1'b1);
    spawn(10'd400, 10'd300, 1'b0);
    check("full_alive", 32'(enemy_alive), 32'hF);
    check("full_ready", 32'(spawn_ready), 32'd0);
    mario_x = 10'd202; mario_y = 10'd170; mario_falling = 1'b1;
    run_frame(b, s, sa, h);
    check("stomp_count", 32'(s), 32'd1);
    check("stomp_cycle", sa, 32'd4);
    check("stomp_nohit", 32'(h), 32'd0);
    check("stomp_score", 32'(score), 32'd1);
    check("stomp_alive", 32'(enemy_alive), 32'hB);
    check("stomp_ready", 32'(spawn_ready), 32'd1);
    mario_x = 10'd1000; mario_y = 10'd1000; mario_falling = 1'b0;
    spawn(10'd60, 10'd50, 1'b0);
    check("refill_alive", 32'(enemy_alive), 32'hF);
    check("refill_x2", 32'(ex(2)), 32'd60);

    do_restart();
    check("restart1_alive", 32'(enemy_alive), 32'd0);
    check("restart1_score", 32'(score), 32'd0);

    // two overlapping enemies: one hit per frame, then invulnerability
    spawn(10'd100, 10'd100, 1'b1);
    spawn(10'd110, 10'd100, 1'b1);
    mario_y = 10'd100;
    mario_x = 10'd107;
    run_frame(b, s, sa, h);
    check("hit1_pulses", 32'(h), 32'd1);
    check("hit1_lives", 32'(lives), 32'd2);
    hit_sum = 0;
    for (int k = 2; k <= 60; k++) begin
      mario_x = W'(105 + 2 * k);
      run_frame(b, s, sa, h);
      hit_sum += h;
    end
    check("invuln_hits", 32'(hit_sum), 32'd0);
    check("invuln_lives", 32'(lives), 32'd2);
    mario_x = W'(105 + 2 * 61);
    run_frame(b, s, sa, h);
    check("hit2_pulses", 32'(h), 32'd1);
    check("hit2_lives", 32'(lives), 32'd1);
    for (int k = 62; k <= 120; k++) begin
      mario_x = W'(105 + 2 * k);
      run_frame(b, s, sa, h);
    end
    check("pre_go_lives", 32'(lives), 32'd1);
    mario_x = W'(105 + 2 * 121);
    run_frame(b, s, sa, h);
    check("go_busy", 32'(b), 32'd1);
    check("go_lives", 32'(lives), 32'd0);
    check("go_flag", 32'(game_over), 32'd1);
    check("go_state", 32'(fsm_state), 32'd2);
    check("go_x0", 32'(ex(0)), 32'd342);
    check("go_x1_skipped", 32'(ex(1)), 32'd350);

    // game over ignores frames and spawns
    run_frame(b, s, sa, h);
    check("go_tick_busy", 32'(b), 32'd0);
    check("go_tick_x0", 32'(ex(0)), 32'd342);
    check("go_ready", 32'(spawn_ready), 32'd0);
    spawn(10'd300, 10'd300, 1'b0);
    check("go_spawn_alive", 32'(enemy_alive), 32'h3);

    do_restart();
    check("restart2_lives", 32'(lives), 32'd3);
    check("restart2_alive", 32'(enemy_alive), 32'd0);
    check("restart2_go", 32'(game_over), 32'd0);

    // frame_tick re-asserted mid-scan
    mario_x = 10'd1000; mario_y = 10'd1000;
    spawn(10'd300, 10'd300, 1'b1);
    check("ovr_clear", 32'(overrun), 32'd0);
    frame_tick = 1'b1;
    step();
    b = 0;
    for (int c = 1; c <= N + 1; c++) begin
      if (busy) b++;
      frame_tick = (c == 2);
      if (c <= N) step();
    end
    frame_tick = 1'b0;
    check("ovr_busy_len", 32'(b), 32'd4);
    check("ovr_idle_after", 32'(busy), 32'd0);
    check("ovr_set", 32'(overrun), 32'd1);
    step();
    run_frame(b, s, sa, h);
    check("ovr_sticky", 32'(overrun), 32'd1);
    check("ovr_next_busy", 32'(b), 32'd4);

    // asynchronous reset in cycle E0+2
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    #2 reset = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_alive", 32'(enemy_alive), 32'd0);
    check("arst_overrun", 32'(overrun), 32'd0);
    check("arst_lives", 32'(lives), 32'd3);
    #1 reset = 1'b0;
    step();
    check("arst_idle", 32'(fsm_state), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule

// File: doc/enemy_swarm_engine.md
# enemy_swarm_engine

Parametrised successor to the fixed two-goomba game logic. It manages a pool of NUM_ENEMIES patrolling enemies. Once per video frame it walks the pool sequentially, one enemy per clock: it moves each live enemy, bounces it off the play-field limits, and checks it against Mario for a stomp or a hit. It also owns lives, invulnerability, score and game-over, and exports flattened enemy coordinates to the VGA renderer.

## Interface
- NUM_ENEMIES, 4, pool size (1..16)
- COORD_W, 10, coordinate width
- CHARACTER_WIDTH, 42, sprite edge in pixels; used as the overlap distance
- X_MIN, 40, left patrol limit (inside the border block)
- X_MAX, 558, right patrol limit (SCREEN_WIDTH − BLOCK_WIDTH − CHARACTER_WIDTH)
- STEP, 2, pixels moved per frame
- MAX_LIVES, 3, lives at reset or restart
- INVULN_FRAMES, 60, frames of invulnerability after a hit

Ports:
- vga_clock  in  1  sole clock
- reset  in  1  asynchronous, active-high
- frame_tick  in  1  one-cycle pulse per frame, issued in vertical blank
- restart  in  1  synchronous clear to reset state
- spawn_valid  in  1  spawn request
- spawn_x, spawn_y  in  COORD_W each  spawn position
- spawn_dir  in  1  initial direction (1 = right)
- spawn_ready  out  1  spawn accepted this cycle when high together with spawn_valid
- mario_x, mario_y  in  COORD_W each  Mario's top-left corner
- mario_falling  in  1  Mario's vertical velocity is downward
- enemy_x, enemy_y  out  NUM_ENEMIES*COORD_W each  enemy i occupies slice [i*COORD_W +: COORD_W]
- enemy_alive  out  NUM_ENEMIES  per-slot live flag
- stomp_pulse, hit_pulse  out  1 each  one-cycle event pulses
- lives  out  4  remaining lives
- score  out  16  stomp count, saturating at 65535
- busy  out  1  scan in progress
- game_over  out  1  high when lives == 0
- overrun  out  1  sticky: frame_tick arrived while busy

## Operation
- FSM states: IDLE, SCAN(idx), GAMEOVER.
- IDLE + frame_tick:
  - go to SCAN with idx = 0.
  - if invuln > 0, invuln decrements by 1 in the same edge.
- SCAN, one enemy per cycle; idx = NUM_ENEMIES−1 returns to IDLE.
  - A dead slot is skipped, but its cycle is still consumed.
- Move, for a live slot:
  - dir = 1: nx = x + STEP. If nx ≥ X_MAX, then nx = X_MAX and dir is cleared.
  - dir = 0: nx = x − STEP. If x < X_MIN + STEP, then nx = X_MIN and dir is set.
  - Compute in COORD_W+1 bits; no wrap is permitted.
- Overlap uses the post-move position nx: |nx − mario_x| < CHARACTER_WIDTH and |y − mario_y| < CHARACTER_WIDTH.
- Stomp: overlap && mario_falling && mario_y < y.
  - Slot killed; stomp_pulse fires; score += 1 (saturating).
- Hit: overlap, not a stomp, and invuln == 0.
  - lives −= 1; invuln = INVULN_FRAMES; hit_pulse fires. The enemy stays alive.
  - Because invuln is now set, at most one hit occurs per frame.
- Overlap while invuln > 0 and not a stomp: no effect.
- lives reaching 0 moves the FSM to GAMEOVER at the end of the current SCAN cycle. The remaining slots are not processed that frame.
- GAMEOVER: frame_tick is ignored, spawn_ready = 0, outputs hold. Only restart or reset exits.
- Spawn:
  - spawn_ready = (state == IDLE) && at least one slot is dead.
  - On accept, the lowest-index dead slot is loaded with spawn_x, spawn_y, spawn_dir and set alive.
  - Simultaneous frame_tick and spawn in IDLE: both act. The new enemy is included in the scan that begins next cycle.
- frame_tick while busy: ignored, and overrun sets (sticky until restart or reset).
- Reset or restart values:
  - all slots dead, x = X_MIN, y = 0, dir = 0
  - lives = MAX_LIVES, score = 0, invuln = 0
  - busy, pulses, game_over and overrun all 0
  - state IDLE
- restart has priority over every other input in its cycle.

## Timing
- frame_tick sampled at edge E0. busy = 1 for cycles E0+1 … E0+NUM_ENEMIES; IDLE again at E0+NUM_ENEMIES+1.
- Slot i is processed in cycle E0+1+i. Its updated x, dir and alive, plus any pulse, are registered at the end of that cycle and visible in cycle E0+2+i.
- Pulses last exactly one cycle. Multiple stomps in one frame give separate pulses in different cycles.
- mario_* must be stable from E0 through E0+NUM_ENEMIES; the block does not re-sample them.
- lives, score and game_over are registered and update the cycle after the causing event.
- All outputs are registered; none depend combinationally on inputs, except spawn_ready, which depends only on state and the alive flags.
- Asynchronous reset takes effect immediately, mid-scan included. Any partial scan is discarded.

## Test plan
- Reset, spawn slot 0 at x = 550, dir = 1, then 5 frame_ticks → x = 552, 554, 556, 558, 556. The dir flips on the frame x reaches 558; busy is high for 4 cycles per frame.
- Fill all 4 slots → spawn_ready = 0. Kill slot 2 by stomp (mario_falling = 1, mario_y = y − 30, same x) → stomp_pulse in cycle E0+4; score = 1; the next spawn lands in slot 2.
- Mario overlaps enemies 0 and 1 in the same frame, not falling → exactly one hit_pulse; lives 3→2; invuln = 60. Continued overlap for the next 59 frames → no hits; frame 61 → lives = 1.
- Three hits spaced by invulnerability → lives = 0, game_over = 1. Further frame_ticks and spawn_valid have no effect. restart → lives = 3, all slots dead, game_over = 0.
- frame_tick re-asserted in cycle E0+2 → scan length unchanged; overrun = 1 and stays set.
- Assert reset during cycle E0+2 → all outputs at reset values in the same cycle, busy = 0.
